mdu: RTL and testbench

Multiply/divide unit for the five-stage MIPS core. It executes MULT, MULTU, DIV and DIVU from the Execute stage and owns the HI/LO registers. MTHI and MTLO write those registers, and MFHI and MFLO read them. While a multi-cycle operation is in flight, the unit raises a stall request to the hazard unit, so instructions that depend on HI/LO wait and all other instructions flow freely.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_div_radix2.sv | 56 +++++
 rtl/mdu.sv | 145 ++++++++++++++
 tb/tb_mdu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared encodings for the multiply/divide unit: operation codes,
//             FSM state constants, iteration count and a sign helper.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // The E-stage op field is 3 bits wide. MFHI and MFLO share one code because
  // the unit only needs to know that a HI/LO read is waiting. The datapath
  // picks hiE or loE from the instruction itself.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MFHI  = 3'd7
  } mdu_op_t;

  localparam mdu_op_t MDU_MFLO = MDU_MFHI;

  // FSM state encoding
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_MUL  = 2'd1;
  localparam mdu_state_t ST_DIV  = 2'd2;
  localparam mdu_state_t ST_FIX  = 2'd3;

  localparam int DIV_ITERS = 32;

  // Two's-complement negate when neg is set. A negated 0x8000_0000 stays
  // 0x8000_0000, which is the correct unsigned magnitude.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_radix2.sv
`default_nettype none
// ============================================================================
//  Module   : div_radix2
//  Purpose  : Unsigned radix-2 restoring divider datapath. The caller loads
//             the operand magnitudes and then pulses step once per iteration.
//  Revision : 1.0  initial release
// ============================================================================
module div_radix2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;

  logic [31:0] w_shift;
  logic [31:0] w_diff;
  logic        w_fits;

  // Trial subtraction. Bit 31 of the remainder is shifted out of w_shift and
  // acts as the 33rd bit of the partial remainder. When that bit is set, the
  // divisor always fits, and the 32-bit difference is still exact.
  assign w_shift = {r_rem[30:0], r_quo[31]};
  assign w_fits  = r_rem[31] | (w_shift >= r_dvs);
  assign w_diff  = w_shift - r_dvs;

  // Load the operands, or run one restoring iteration.
  // A zero divisor always fits, so it leaves an all-ones quotient and the
  // dividend as the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_dvs <= divisor;
    end else if (step) begin
      r_rem <= w_fits ? w_diff : w_shift;
      r_quo <= {r_quo[30:0], w_fits};
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module   : mdu
//  Purpose  : MIPS multiply/divide unit. Owns HI/LO, runs MULT/MULTU/DIV/DIVU
//             and requests a stall while a HI/LO user waits on a busy unit.
//  Revision : 1.0  initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mdu_opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        stallE,
  output logic [31:0] hiE,
  output logic [31:0] loE,
  output logic        busy,
  output logic        mdu_stall
);

  localparam int c_MAX_CNT = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

  mdu_state_t          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic signed [32:0]  r_mul_a;
  logic signed [32:0]  r_mul_b;
  logic                r_neg_q;
  logic                r_neg_r;

  mdu_op_t     w_op;
  logic        w_accept;
  logic        w_is_div;
  logic        w_mul_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic        w_mul_done;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_op         = mdu_op_t'(mdu_opE);
  assign w_accept     = (w_op != MDU_NONE) && !stallE && !busy;
  assign w_is_div     = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_mul_signed = (w_op == MDU_MULT);
  assign w_neg_a      = (w_op == MDU_DIV) && srcaE[31];
  assign w_neg_b      = (w_op == MDU_DIV) && srcbE[31];
  assign w_mag_a      = cond_neg(srcaE, w_neg_a);
  assign w_mag_b      = cond_neg(srcbE, w_neg_b);
  assign w_mul_done   = (r_state == ST_MUL) && (r_cnt == c_CNT_W'(MUL_LAT));

  // Only the low 64 bits of the 33x33 product are significant.
  assign w_prod = 64'(r_mul_a) * 64'(r_mul_b);

  assign busy      = (r_state != ST_IDLE);
  assign mdu_stall = busy && (w_op != MDU_NONE);
  assign hiE       = r_hi;
  assign loE       = r_lo;

  div_radix2 u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept && w_is_div),
    .step      (r_state == ST_DIV),
    .dividend  (w_mag_a),
    .divisor   (w_mag_b),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Sequence MUL latency cycles, DIV iterations and the sign-fix cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && ((w_op == MDU_MULT) || (w_op == MDU_MULTU))) begin
            r_state <= ST_MUL;
            r_cnt   <= c_CNT_W'(1);
          end else if (w_accept && w_is_div) begin
            r_state <= ST_DIV;
            r_cnt   <= '0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) r_state <= ST_IDLE;
          else            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
        ST_DIV: begin
          if (r_cnt == c_CNT_W'(DIV_ITERS - 1)) r_state <= ST_FIX;
          else                                  r_cnt   <= r_cnt + c_CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the multiply operands and the result signs when an op is accepted.
  // A zero divisor leaves the quotient unsigned, so it reads as all ones for
  // both signednesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_mul_a <= {w_mul_signed & srcaE[31], srcaE};
      r_mul_b <= {w_mul_signed & srcbE[31], srcbE};
      r_neg_q <= (w_neg_a ^ w_neg_b) && (srcbE != 32'd0);
      r_neg_r <= w_neg_a;
    end
  end

  // HI/LO writes: MT at accept, the product on the last MUL cycle, and the
  // sign-corrected remainder/quotient in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept && (w_op == MDU_MTHI)) begin
      r_hi <= srcaE;
    end else if (w_accept && (w_op == MDU_MTLO)) begin
      r_lo <= srcaE;
    end else if (w_mul_done) begin
      r_hi <= w_prod[63:32];
      r_lo <= w_prod[31:0];
    end else if (r_state == ST_FIX) begin
      r_hi <= cond_neg(w_rem, r_neg_r);
      r_lo <= cond_neg(w_quo, r_neg_q);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu
//  Purpose  : Directed self-checking bench for the multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu;
  import mdu_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  mdu_opE = MDU_NONE;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        ext_stall = 1'b0;
  logic        stallE;
  logic [31:0] hiE;
  logic [31:0] loE;
  logic        busy;
  logic        mdu_stall;

  int n_pass  = 0;
  int n_total = 0;

  // The hazard unit folds the MDU stall request into stallE.
  assign stallE = ext_stall | mdu_stall;

  mdu #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdu_opE   (mdu_opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .stallE    (stallE),
    .hiE       (hiE),
    .loE       (loE),
    .busy      (busy),
    .mdu_stall (mdu_stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op in E for a single accept edge, then clear E.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_opE = op; srcaE = a; srcbE = b;
    tick;
    mdu_opE = MDU_NONE;
  endtask

  // Count samples with busy high, bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick;
    end
  endtask

  task automatic test_reset;
    mdu_opE = MDU_DIV;
    #2 rst_n = 1'b0;
    tick; tick;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (mdu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mdu_stall); else n_pass++;
    n_total++; if (hiE !== 32'h0) $display("FAIL reset_hi: got %h want 0", hiE); else n_pass++;
    n_total++; if (loE !== 32'h0) $display("FAIL reset_lo: got %h want 0", loE); else n_pass++;
    mdu_opE = MDU_NONE;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_mult;
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'h2);
    n_total++; if (busy !== 1'b1) $display("FAIL mult_busy0: got %b want 1", busy); else n_pass++;
    n_total++; if (loE !== 32'h0) $display("FAIL mult_lo_early: got %h want 0", loE); else n_pass++;
    tick;
    n_total++; if (busy !== 1'b1) $display("FAIL mult_busy1: got %b want 1", busy); else n_pass++;
    n_total++; if (loE !== 32'h0) $display("FAIL mult_lo_early2: got %h want 0", loE); else n_pass++;
    tick;
    n_total++; if (busy !== 1'b0) $display("FAIL mult_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (hiE !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hiE); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want fffffffe", loE); else n_pass++;

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
    tick;
    n_total++; if (hiE !== 32'hFFFF_FFFF) $display("FAIL multu_hi_early: got %h want ffffffff", hiE); else n_pass++;
    tick;
    n_total++; if (busy !== 1'b0) $display("FAIL multu_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (hiE !== 32'h1) $display("FAIL multu_hi: got %h want 00000001", hiE); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", loE); else n_pass++;
  endtask

  task automatic test_div;
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_busy(n);
    n_total++; if (n != 33) $display("FAIL div_busy_cycles: got %0d want 33", n); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFFD) $display("FAIL div_neg7_lo: got %h want fffffffd", loE); else n_pass++;
    n_total++; if (hiE !== 32'hFFFF_FFFF) $display("FAIL div_neg7_hi: got %h want ffffffff", hiE); else n_pass++;
  endtask

  task automatic test_mflo_stall;
    int n;
    issue(MDU_DIV, 32'd100, 32'hFFFF_FFF9);
    mdu_opE = MDU_MFLO;
    #1;
    n = 0;
    while (mdu_stall === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    n_total++; if (n != 33) $display("FAIL mflo_stall_cycles: got %0d want 33", n); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFF2) $display("FAIL mflo_lo: got %h want fffffff2", loE); else n_pass++;
    n_total++; if (hiE !== 32'h2) $display("FAIL mflo_hi: got %h want 00000002", hiE); else n_pass++;
    mdu_opE = MDU_NONE;
    tick;
  endtask

  task automatic test_div_edges;
    int n;
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n);
    n_total++; if (loE !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", loE); else n_pass++;
    n_total++; if (hiE !== 32'h0) $display("FAIL div_ovf_hi: got %h want 0", hiE); else n_pass++;
    issue(MDU_DIVU, 32'd5, 32'd0);
    wait_busy(n);
    n_total++; if (hiE !== 32'd5) $display("FAIL divu_zero_hi: got %h want 00000005", hiE); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFFF) $display("FAIL divu_zero_lo: got %h want ffffffff", loE); else n_pass++;
    issue(MDU_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_busy(n);
    n_total++; if (hiE !== 32'hFFFF_FFFB) $display("FAIL div_zero_hi: got %h want fffffffb", hiE); else n_pass++;
    n_total++; if (loE !== 32'hFFFF_FFFF) $display("FAIL div_zero_lo: got %h want ffffffff", loE); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) tick;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (hiE !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hiE); else n_pass++;
    n_total++; if (loE !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", loE); else n_pass++;
    tick;
    rst_n = 1'b1;
    tick;
    issue(MDU_DIV, 32'd100, 32'd7);
    wait_busy(n);
    n_total++; if (n != 33) $display("FAIL rstmid_div_cycles: got %0d want 33", n); else n_pass++;
    n_total++; if (loE !== 32'd14) $display("FAIL rstmid_div_lo: got %h want 0000000e", loE); else n_pass++;
    n_total++; if (hiE !== 32'd2) $display("FAIL rstmid_div_hi: got %h want 00000002", hiE); else n_pass++;
  endtask

  task automatic test_mt_stall;
    ext_stall = 1'b1;
    mdu_opE = MDU_MTHI; srcaE = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_total++; if (hiE !== 32'd2) $display("FAIL mthi_stalled%0d: got %h want 00000002", i, hiE); else n_pass++;
    end
    ext_stall = 1'b0;
    tick;
    mdu_opE = MDU_NONE;
    n_total++; if (hiE !== 32'h1234) $display("FAIL mthi_write: got %h want 00001234", hiE); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else n_pass++;
    issue(MDU_MTLO, 32'h5678, 32'h0);
    n_total++; if (loE !== 32'h5678) $display("FAIL mtlo_write: got %h want 00005678", loE); else n_pass++;
    n_total++; if (hiE !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h want 00001234", hiE); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(MDU_MULTU, 32'd3, 32'd5);
    mdu_opE = MDU_DIV; srcaE = 32'd20; srcbE = 32'd3;
    #1;
    wait_busy(n);
    n_total++; if (n != MUL_LAT) $display("FAIL b2b_mul_cycles: got %0d want %0d", n, MUL_LAT); else n_pass++;
    n_total++; if (loE !== 32'd15) $display("FAIL b2b_mul_lo: got %h want 0000000f", loE); else n_pass++;
    n_total++; if (hiE !== 32'd0) $display("FAIL b2b_mul_hi: got %h want 0", hiE); else n_pass++;
    tick;
    mdu_opE = MDU_NONE;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_div_accept: got %b want 1", busy); else n_pass++;
    wait_busy(n);
    n_total++; if (n != 33) $display("FAIL b2b_div_cycles: got %0d want 33", n); else n_pass++;
    n_total++; if (loE !== 32'd6) $display("FAIL b2b_div_lo: got %h want 00000006", loE); else n_pass++;
    n_total++; if (hiE !== 32'd2) $display("FAIL b2b_div_hi: got %h want 00000002", hiE); else n_pass++;
    tick;
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_single_accept: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mflo_stall;
    test_div_edges;
    test_reset_mid;
    test_mt_stall;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
